// File: rtl/parallax_layer_engine_pkg.sv
// Shared types and codes for the parallax layer engine.
// Holds cfg field codes, dither codes, ctrl bit positions and the layer config struct.
package parallax_pkg;

    localparam int CFG_COLOR_W = 6;

    localparam logic [1:0] FLD_SPEED_X = 2'd0;
    localparam logic [1:0] FLD_SPEED_Y = 2'd1;
    localparam logic [1:0] FLD_CTRL    = 2'd2;
    localparam logic [1:0] FLD_COLOR   = 2'd3;

    localparam logic [1:0] DITH_NONE = 2'd0;
    localparam logic [1:0] DITH_A    = 2'd1;
    localparam logic [1:0] DITH_B    = 2'd2;
    localparam logic [1:0] DITH_C    = 2'd3;

    // ctrl = {1'b0, en, dither[1:0], 1'b0, cell_shift[2:0]}
    localparam int CTRL_EN      = 6;
    localparam int CTRL_DITH_LO = 4;
    localparam int CTRL_CS_LO   = 0;

    typedef struct packed {
        logic [7:0]             speed_x;
        logic [7:0]             speed_y;
        logic                   en;
        logic [1:0]             dither;
        logic [2:0]             cell_shift;
        logic [CFG_COLOR_W-1:0] color;
    } layer_cfg_t;

endpackage

// File: rtl/parallax_layer_engine_if.sv
// Configuration write bus of the parallax layer engine.
// master drives cfg_we/cfg_layer/cfg_field/cfg_wdata; slave (the engine) receives them.
interface parallax_cfg_if;
    logic       cfg_we;
    logic [3:0] cfg_layer;
    logic [1:0] cfg_field;
    logic [7:0] cfg_wdata;

    modport master (output cfg_we, cfg_layer, cfg_field, cfg_wdata);
    modport slave  (input  cfg_we, cfg_layer, cfg_field, cfg_wdata);
endinterface

// File: rtl/parallax_layer_engine_layer.sv
// One parallax layer: shadow/active config, scroll accumulators and hit bit.
// Ports: clk, rst_n, wr/field/wdata (decoded write), frame_tick, advance, pix_x/pix_y in; hit, color out.
module parallax_layer
    import parallax_pkg::*;
#(
    parameter int IDX     = 0,
    parameter int COORD_W = 10,
    parameter int FRAC_W  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr,
    input  logic [1:0]             field,
    input  logic [7:0]             wdata,
    input  logic                   frame_tick,
    input  logic                   advance,
    input  logic [COORD_W-1:0]     pix_x,
    input  logic [COORD_W-1:0]     pix_y,
    output logic                   hit,
    output logic [CFG_COLOR_W-1:0] color
);

    localparam int OW = COORD_W + FRAC_W;
    localparam logic [3:0] KMAX = 4'(COORD_W - 1);
    localparam layer_cfg_t CFG_RST = '{
        speed_x: '0, speed_y: '0, en: 1'b0, dither: '0,
        cell_shift: 3'(IDX % 8), color: '0
    };

    layer_cfg_t shadow_q, active_q, shadow_nxt;
    logic [OW-1:0] off_x_q, off_y_q;

    // A write in the tick cycle lands in shadow_nxt, so it is part of the copy.
    always_comb begin
        shadow_nxt = shadow_q;
        if (wr) begin
            unique case (field)
                FLD_SPEED_X: shadow_nxt.speed_x = wdata;
                FLD_SPEED_Y: shadow_nxt.speed_y = wdata;
                FLD_CTRL: begin
                    shadow_nxt.en         = wdata[CTRL_EN];
                    shadow_nxt.dither     = wdata[CTRL_DITH_LO +: 2];
                    shadow_nxt.cell_shift = wdata[CTRL_CS_LO +: 3];
                end
                FLD_COLOR: shadow_nxt.color = wdata[CFG_COLOR_W-1:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= CFG_RST;
            active_q <= CFG_RST;
            off_x_q  <= '0;
            off_y_q  <= '0;
        end else begin
            shadow_q <= shadow_nxt;
            if (frame_tick) active_q <= shadow_nxt;
            if (advance) begin
                off_x_q <= off_x_q + {{(OW-8){active_q.speed_x[7]}}, active_q.speed_x};
                off_y_q <= off_y_q + {{(OW-8){active_q.speed_y[7]}}, active_q.speed_y};
            end
        end
    end

    logic [COORD_W-1:0] lx, ly, cx;
    logic [3:0]         kraw, k;
    logic               dith;

    assign lx   = pix_x + off_x_q[OW-1:FRAC_W];
    assign ly   = pix_y + off_y_q[OW-1:FRAC_W];
    assign cx   = lx ^ ly;
    assign kraw = {1'b0, active_q.cell_shift} + 4'd2;
    assign k    = (kraw > KMAX) ? KMAX : kraw;

    always_comb begin
        dith = 1'b1;
        unique case (active_q.dither)
            DITH_NONE: dith = 1'b1;
            DITH_A:    dith = pix_y[1] ^ pix_x[0];
            DITH_B:    dith = ~pix_y[0] ^ pix_x[1];
            DITH_C:    dith = pix_x[0] ^ pix_y[0];
        endcase
    end

    assign hit   = active_q.en & cx[k] & dith;
    assign color = active_q.color;

endmodule

// File: rtl/parallax_layer_engine.sv
// N-layer parallax checkerboard renderer with a 2-cycle registered pixel pipeline.
// Ports: clk, rst_n, pix_x/pix_y, video_active, hsync_in/vsync_in, frame_tick, run_en, step, cfg bus in;
// rgb, hsync_out, vsync_out, frame_cnt out.
module parallax_layer_engine
    import parallax_pkg::*;
#(
    parameter int NUM_LAYERS = 5,
    parameter int COORD_W    = 10,
    parameter int FRAC_W     = 2,
    parameter int COLOR_W    = 6,
    parameter int FCNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [COORD_W-1:0] pix_x,
    input  logic [COORD_W-1:0] pix_y,
    input  logic               video_active,
    input  logic               hsync_in,
    input  logic               vsync_in,
    input  logic               frame_tick,
    input  logic               run_en,
    input  logic               step,
    parallax_cfg_if.slave      cfg,
    output logic [COLOR_W-1:0] rgb,
    output logic               hsync_out,
    output logic               vsync_out,
    output logic [FCNT_W-1:0]  frame_cnt
);

    logic                  step_pending_q;
    logic                  advance;
    logic [NUM_LAYERS-1:0] hit, hit_q;
    logic [COLOR_W-1:0]    lcol [NUM_LAYERS];
    logic [COLOR_W-1:0]    bg_shadow_q, bg_active_q, bg_nxt, pix_nxt;
    logic                  va_q, hs_q, vs_q;

    assign advance = frame_tick & (run_en | step_pending_q);

    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
        parallax_layer #(
            .IDX(i), .COORD_W(COORD_W), .FRAC_W(FRAC_W)
        ) u_layer (
            .clk(clk), .rst_n(rst_n),
            .wr(cfg.cfg_we && cfg.cfg_layer == 4'(i)),
            .field(cfg.cfg_field), .wdata(cfg.cfg_wdata),
            .frame_tick(frame_tick), .advance(advance),
            .pix_x(pix_x), .pix_y(pix_y),
            .hit(hit[i]), .color(lcol[i])
        );
    end

    // Background only has a colour field; it is shadowed like the layers.
    always_comb begin
        bg_nxt = bg_shadow_q;
        if (cfg.cfg_we && cfg.cfg_layer == 4'(NUM_LAYERS)
            && cfg.cfg_field == FLD_COLOR)
            bg_nxt = cfg.cfg_wdata[COLOR_W-1:0];
    end

    // A step arriving with a tick is held over for the next tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_pending_q <= 1'b0;
            frame_cnt      <= '0;
            bg_shadow_q    <= '0;
            bg_active_q    <= '0;
        end else begin
            bg_shadow_q <= bg_nxt;
            if (frame_tick) begin
                bg_active_q    <= bg_nxt;
                step_pending_q <= step & ~run_en;
            end else if (step & ~run_en) begin
                step_pending_q <= 1'b1;
            end
            if (advance) frame_cnt <= frame_cnt + 1'b1;
        end
    end

    always_comb begin
        pix_nxt = bg_active_q;
        for (int i = NUM_LAYERS - 1; i >= 0; i--)
            if (hit_q[i]) pix_nxt = lcol[i];
        if (!va_q) pix_nxt = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q     <= '0;
            va_q      <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            rgb       <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
        end else begin
            hit_q     <= hit;
            va_q      <= video_active;
            hs_q      <= hsync_in;
            vs_q      <= vsync_in;
            rgb       <= pix_nxt;
            hsync_out <= hs_q;
            vsync_out <= vs_q;
        end
    end

endmodule

// File: tb/tb_parallax_layer_engine.sv
// Randomized self-checking bench for parallax_layer_engine.
// A frame-level reference model predicts rgb, sync delay and frame_cnt.
module tb_parallax_layer_engine;

    localparam int N = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [9:0] pix_x, pix_y;
    logic       video_active, hsync_in, vsync_in;
    logic       frame_tick, run_en, step;
    logic [5:0] rgb;
    logic       hsync_out, vsync_out;
    logic [15:0] frame_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    parallax_cfg_if cfg ();

    parallax_layer_engine #(
        .NUM_LAYERS(N), .COORD_W(10), .FRAC_W(2), .COLOR_W(6), .FCNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pix_x(pix_x), .pix_y(pix_y),
        .video_active(video_active), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .frame_tick(frame_tick), .run_en(run_en), .step(step), .cfg(cfg),
        .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .frame_cnt(frame_cnt)
    );

    typedef struct {
        int sx; int sy; int en; int dith; int cs; int col;
    } mcfg_t;

    mcfg_t sh [N];
    mcfg_t ac [N];
    int    bg_sh, bg_ac, fcnt;
    int    offx [N];
    int    offy [N];
    bit    sp;

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            sh[i] = '{0, 0, 0, 0, i % 8, 0};
            ac[i] = sh[i];
            offx[i] = 0;
            offy[i] = 0;
        end
        bg_sh = 0; bg_ac = 0; fcnt = 0; sp = 0;
    endtask

    function automatic int sx8(int d);
        return (d & 128) != 0 ? (d & 255) - 256 : (d & 255);
    endfunction

    task automatic m_write(int l, int f, int d);
        if (l < N) begin
            case (f)
                0: sh[l].sx = sx8(d);
                1: sh[l].sy = sx8(d);
                2: begin
                    sh[l].en = (d >> 6) & 1;
                    sh[l].dith = (d >> 4) & 3;
                    sh[l].cs = d & 7;
                end
                default: sh[l].col = d & 63;
            endcase
        end else if (l == N && f == 3) begin
            bg_sh = d & 63;
        end
    endtask

    function automatic logic [5:0] m_rgb(int x, int y, bit va);
        int lx, ly, k, cb, d;
        if (!va) return 6'h00;
        for (int i = 0; i < N; i++) begin
            if (ac[i].en == 0) continue;
            lx = (x + (offx[i] >> 2)) % 1024;
            ly = (y + (offy[i] >> 2)) % 1024;
            k = ac[i].cs + 2;
            if (k > 9) k = 9;
            cb = ((lx >> k) ^ (ly >> k)) & 1;
            case (ac[i].dith)
                0: d = 1;
                1: d = ((y >> 1) ^ x) & 1;
                2: d = ((y & 1) ^ 1) ^ ((x >> 1) & 1);
                default: d = (x ^ y) & 1;
            endcase
            if (cb == 1 && d == 1) return 6'(ac[i].col);
        end
        return 6'(bg_ac);
    endfunction

    // One clock of control stimulus, with the model stepped alongside.
    task automatic cyc(bit tk, bit st, bit we, int l, int f, int d);
        frame_tick = tk;
        step = st;
        cfg.cfg_we = we;
        cfg.cfg_layer = 4'(l);
        cfg.cfg_field = 2'(f);
        cfg.cfg_wdata = 8'(d);
        @(negedge clk);
        if (we) m_write(l, f, d);
        if (tk) begin
            if (run_en || sp) begin
                for (int i = 0; i < N; i++) begin
                    offx[i] = (offx[i] + ac[i].sx) & 4095;
                    offy[i] = (offy[i] + ac[i].sy) & 4095;
                end
                fcnt = (fcnt + 1) & 65535;
            end
            for (int i = 0; i < N; i++) ac[i] = sh[i];
            bg_ac = bg_sh;
            sp = st && !run_en;
        end else if (st && !run_en) begin
            sp = 1;
        end
        frame_tick = 0;
        step = 0;
        cfg.cfg_we = 0;
    endtask

    task automatic wr(int l, int f, int d);
        cyc(0, 0, 1, l, f, d);
    endtask

    task automatic tick();
        cyc(1, 0, 0, 0, 0, 0);
    endtask

    task automatic sample(int x, int y, bit va,
                          output logic [5:0] obs, output logic [5:0] exp);
        pix_x = 10'(x);
        pix_y = 10'(y);
        video_active = va;
        exp = m_rgb(x, y, va);
        @(negedge clk);
        @(negedge clk);
        obs = rgb;
    endtask

    task automatic apply_reset();
        rst_n = 0;
        run_en = 0; step = 0; frame_tick = 0;
        hsync_in = 0; vsync_in = 0; video_active = 1;
        pix_x = 0; pix_y = 0;
        cfg.cfg_we = 0; cfg.cfg_layer = 0; cfg.cfg_field = 0; cfg.cfg_wdata = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        m_reset();
    endtask

    task automatic test_reset();
        bit hp, vp;
        apply_reset();
        rst_n = 0;
        #1;
        total++;
        if (rgb !== 6'h00 || frame_cnt !== 16'h0) begin
            bad++;
            $display("FAIL reset_out rgb=%h fcnt=%h want 0", rgb, frame_cnt);
        end
        total++;
        if (hsync_out !== 1'b0 || vsync_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_sync hs=%b vs=%b want 0", hsync_out, vsync_out);
        end
        @(negedge clk);
        rst_n = 1;
        hp = 0; vp = 0;
        for (int c = 0; c < 40; c++) begin
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
            pix_x = 10'($urandom);
            pix_y = 10'($urandom);
            video_active = 1'($urandom);
            @(negedge clk);
            total++;
            if (hsync_out !== hp || vsync_out !== vp) begin
                bad++;
                $display("FAIL sync_delay c=%0d got=%b%b want=%b%b",
                         c, hsync_out, vsync_out, hp, vp);
            end
            total++;
            if (rgb !== 6'h00 || frame_cnt !== 16'h0) begin
                bad++;
                $display("FAIL idle c=%0d rgb=%h fcnt=%h want 0", c, rgb, frame_cnt);
            end
            hp = hsync_in;
            vp = vsync_in;
        end
    endtask

    task automatic test_layer_basic();
        logic [5:0] o, e;
        apply_reset();
        wr(0, 2, 8'h42);
        wr(0, 3, 8'h3F);
        wr(N, 3, 8'h05);
        sample(16, 0, 1, o, e);
        total++;
        if (o !== 6'h00) begin
            bad++;
            $display("FAIL pre_tick rgb=%h want 00", o);
        end
        tick();
        sample(16, 0, 1, o, e);
        total++;
        if (o !== 6'h3F) begin
            bad++;
            $display("FAIL l0_hit rgb=%h want 3f", o);
        end
        sample(0, 0, 1, o, e);
        total++;
        if (o !== 6'h05) begin
            bad++;
            $display("FAIL l0_bg rgb=%h want 05", o);
        end
        pix_x = 10'd16;
        @(negedge clk);
        total++;
        if (rgb !== 6'h05) begin
            bad++;
            $display("FAIL latency_1 rgb=%h want 05", rgb);
        end
        @(negedge clk);
        total++;
        if (rgb !== 6'h3F) begin
            bad++;
            $display("FAIL latency_2 rgb=%h want 3f", rgb);
        end
        for (int n = 0; n < 16; n++) begin
            sample(int'($urandom_range(1023)), int'($urandom_range(1023)), 1, o, e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL basic_rand rgb=%h want %h", o, e);
            end
        end
    endtask

    task automatic test_scroll();
        logic [5:0] o, e;
        apply_reset();
        wr(0, 2, 8'h42);
        wr(0, 3, 8'h3F);
        wr(N, 3, 8'h05);
        wr(0, 0, 8'h02);
        tick();
        run_en = 1;
        repeat (4) tick();
        total++;
        if (frame_cnt !== 16'd4) begin
            bad++;
            $display("FAIL scroll_fcnt got=%0d want 4", frame_cnt);
        end
        sample(14, 0, 1, o, e);
        total++;
        if (o !== 6'h3F) begin
            bad++;
            $display("FAIL scroll_edge_in rgb=%h want 3f", o);
        end
        sample(13, 0, 1, o, e);
        total++;
        if (o !== 6'h05) begin
            bad++;
            $display("FAIL scroll_edge_out rgb=%h want 05", o);
        end
        wr(0, 0, 8'hFC);
        repeat (6) tick();
        total++;
        if (frame_cnt !== 16'(fcnt)) begin
            bad++;
            $display("FAIL scroll_fcnt2 got=%0d want %0d", frame_cnt, fcnt);
        end
        for (int n = 0; n < 24; n++) begin
            sample(int'($urandom_range(1023)), int'($urandom_range(63)), 1, o, e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL scroll_wrap rgb=%h want %h", o, e);
            end
        end
        run_en = 0;
    endtask

    task automatic test_dither_overlap();
        logic [5:0] o, e;
        apply_reset();
        wr(0, 2, 8'h52);
        wr(0, 3, 8'h3F);
        wr(1, 2, 8'h42);
        wr(1, 3, 8'h2A);
        wr(N, 3, 8'h05);
        tick();
        sample(16, 0, 1, o, e);
        total++;
        if (o !== 6'h2A) begin
            bad++;
            $display("FAIL dith_off rgb=%h want 2a", o);
        end
        sample(17, 0, 1, o, e);
        total++;
        if (o !== 6'h3F) begin
            bad++;
            $display("FAIL dith_on rgb=%h want 3f", o);
        end
        sample(17, 0, 0, o, e);
        total++;
        if (o !== 6'h00) begin
            bad++;
            $display("FAIL blank rgb=%h want 00", o);
        end
        for (int n = 0; n < 32; n++) begin
            sample(int'($urandom_range(1023)), int'($urandom_range(1023)),
                   $urandom_range(3) != 0, o, e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL dith_rand rgb=%h want %h", o, e);
            end
        end
    endtask

    task automatic test_pause_step();
        logic [5:0] o, e;
        apply_reset();
        wr(0, 2, 8'h42);
        wr(0, 3, 8'h3F);
        wr(N, 3, 8'h05);
        wr(0, 0, 8'h10);
        tick();
        repeat (3) tick();
        sample(15, 0, 1, o, e);
        total++;
        if (frame_cnt !== 16'd0 || o !== 6'h05) begin
            bad++;
            $display("FAIL paused fcnt=%0d rgb=%h want 0/05", frame_cnt, o);
        end
        cyc(0, 1, 0, 0, 0, 0);
        tick();
        sample(12, 0, 1, o, e);
        total++;
        if (frame_cnt !== 16'd1 || o !== 6'h3F) begin
            bad++;
            $display("FAIL step_once fcnt=%0d rgb=%h want 1/3f", frame_cnt, o);
        end
        cyc(1, 1, 0, 0, 0, 0);
        total++;
        if (frame_cnt !== 16'd1) begin
            bad++;
            $display("FAIL step_coincident fcnt=%0d want 1", frame_cnt);
        end
        tick();
        total++;
        if (frame_cnt !== 16'd2) begin
            bad++;
            $display("FAIL step_deferred fcnt=%0d want 2", frame_cnt);
        end
        tick();
        sample(8, 0, 1, o, e);
        total++;
        if (frame_cnt !== 16'd2 || o !== 6'h3F) begin
            bad++;
            $display("FAIL step_consumed fcnt=%0d rgb=%h want 2/3f", frame_cnt, o);
        end
        for (int n = 0; n < 12; n++) begin
            sample(int'($urandom_range(1023)), int'($urandom_range(1023)), 1, o, e);
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL step_rand rgb=%h want %h", o, e);
            end
        end
    endtask

    task automatic test_cfg_and_reset();
        logic [5:0] o, e;
        apply_reset();
        wr(0, 2, 8'h42);
        wr(N, 3, 8'h05);
        cyc(1, 0, 1, 0, 3, 8'h11);
        sample(16, 0, 1, o, e);
        total++;
        if (o !== 6'h11) begin
            bad++;
            $display("FAIL tick_write rgb=%h want 11", o);
        end
        wr(7, 3, 8'h3F);
        wr(7, 2, 8'h00);
        wr(N, 0, 8'h3F);
        wr(N, 2, 8'h00);
        tick();
        sample(16, 0, 1, o, e);
        total++;
        if (o !== 6'h11) begin
            bad++;
            $display("FAIL ignore_hit rgb=%h want 11", o);
        end
        sample(0, 0, 1, o, e);
        total++;
        if (o !== 6'h05) begin
            bad++;
            $display("FAIL ignore_bg rgb=%h want 05", o);
        end
        wr(0, 0, 8'h0C);
        tick();
        run_en = 1;
        repeat (3) tick();
        sample(16, 0, 1, o, e);
        total++;
        if (o !== e || frame_cnt !== 16'(fcnt)) begin
            bad++;
            $display("FAIL pre_reset rgb=%h fcnt=%0d want %h/%0d", o, frame_cnt, e, fcnt);
        end
        run_en = 0;
        pix_x = 10'd0;
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        total++;
        if (rgb !== 6'h00 || frame_cnt !== 16'h0) begin
            bad++;
            $display("FAIL async_reset rgb=%h fcnt=%h want 0", rgb, frame_cnt);
        end
        @(negedge clk);
        rst_n = 1;
        m_reset();
        wr(0, 2, 8'h42);
        wr(0, 3, 8'h3F);
        wr(N, 3, 8'h05);
        tick();
        sample(15, 0, 1, o, e);
        total++;
        if (o !== 6'h05 || frame_cnt !== 16'h0) begin
            bad++;
            $display("FAIL post_reset_off rgb=%h fcnt=%0d want 05/0", o, frame_cnt);
        end
        sample(16, 0, 1, o, e);
        total++;
        if (o !== 6'h3F) begin
            bad++;
            $display("FAIL post_reset_hit rgb=%h want 3f", o);
        end
    endtask

    initial begin
        test_reset();
        test_layer_basic();
        test_scroll();
        test_dither_overlap();
        test_pause_step();
        test_cfg_and_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
